glb_psum_acc: RTL and testbench
===============================

GLB_PSUM_ACC -- requirements
Module: glb_psum_acc

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 16, psum word width in bits.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 10, address width; DEPTH = 2^ADDR_BITWIDTH words.
REQ-003 SHALL have parameter X_dim, default 3, words returned per vector read (1..DEPTH).
REQ-004 SHALL have ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  start whole-memory clear
- busy  out  1  clear in progress
- read_req  in  1  scalar read request
- r_addr  in  ADDR_BITWIDTH  scalar read address
- r_data  out  DATA_BITWIDTH  scalar read data
- r_valid  out  1  r_data valid
- read_req_inter  in  1  vector read request
- r_addr_inter  in  ADDR_BITWIDTH  vector base address
- r_data_inter  out  DATA_BITWIDTH*X_dim  vector data; word k in bits [k*DATA_BITWIDTH +: DATA_BITWIDTH]
- read_en_inter  out  1  r_data_inter valid
- write_en  in  1  write request
- acc_en  in  1  1 = accumulate, 0 = overwrite
- w_addr  in  ADDR_BITWIDTH  write address
- w_data  in  DATA_BITWIDTH  write data / addend
- sat_flag  out  1  sticky saturation flag (REQ-020)

Function
REQ-005 SHALL implement a two-state FSM: IDLE, CLEAR.
REQ-006 IDLE, clear_req=1 -> CLEAR next cycle, clear pointer=0, busy=1; read/write requests in that same cycle are still serviced.
REQ-007 CLEAR: one word per cycle, mem[ptr]=0, ptr+1; after writing DEPTH-1 -> IDLE, busy=0 next cycle; total clear = DEPTH cycles with busy=1.
REQ-008 In CLEAR, read_req, read_req_inter, write_en and clear_req SHALL be ignored; r_valid=0, read_en_inter=0.
REQ-009 Scalar read: read_req=1 in IDLE at cycle N -> r_data=mem[r_addr], r_valid=1 at cycle N+1 (1-cycle latency).
REQ-010 read_req=0 -> r_valid=0 next cycle; r_data holds its last value.
REQ-011 Vector read: read_req_inter=1 at cycle N -> word k = mem[(r_addr_inter+k) mod DEPTH], k=0..X_dim-1, read_en_inter=1 at N+1; address wraps past DEPTH-1 to 0.
REQ-012 read_req_inter=0 -> read_en_inter=0 and r_data_inter=0 next cycle.
REQ-013 Overwrite: write_en=1, acc_en=0 -> mem[w_addr]=w_data at the clock edge.
REQ-014 Accumulate: write_en=1, acc_en=1 -> mem[w_addr]=mem[w_addr]+w_data, single-cycle read-modify-write; back-to-back accumulates to one address SHALL each see the prior result.
REQ-015 Addition two's-complement signed; overflow per REQ-020.
REQ-016 Read and write to the same address in one cycle: read returns pre-write value (read-first), scalar and vector.
REQ-017 Scalar and vector reads and a write SHALL all be serviceable in the same cycle.

Reset
REQ-018 reset=1 at an edge -> state=IDLE, ptr=0, busy=0, r_data=0, r_valid=0, r_data_inter=0, read_en_inter=0, sat_flag=0; reset has priority over all inputs.
REQ-019 Reset SHALL NOT initialise memory; reset mid-CLEAR aborts the clear, leaving memory partially cleared; writes are blocked while reset=1.

Configuration
REQ-020 With macro GLB_PSUM_SAT_EN defined, accumulate SHALL saturate to max positive / min negative DATA_BITWIDTH-bit value, setting sat_flag=1 (sticky, cleared by reset or on entering CLEAR); without it, accumulate wraps modulo 2^DATA_BITWIDTH and sat_flag is tied to 0.

Verification
REQ-021 Overwrite mem[5]=100; read_req r_addr=5 -> next cycle r_data=100, r_valid=1.
REQ-022 mem[7]=10; accumulate w_data=5 on 3 consecutive cycles addr 7 -> read gives 25.
REQ-023 DEPTH=1024, X_dim=3, mem[1023]=1, mem[0]=2, mem[1]=3; vector read base 1023 -> r_data_inter={3,2,1}, read_en_inter=1.
REQ-024 clear_req after filling memory -> busy=1 exactly 1024 cycles, write_en ignored during it, all reads then 0.
REQ-025 DATA_BITWIDTH=16, mem[0]=32767, accumulate +1: with GLB_PSUM_SAT_EN -> 32767, sat_flag=1; without -> -32768, sat_flag=0.
REQ-026 reset asserted at clear cycle 100 -> busy=0 next cycle, mem[0..99]=0, mem[100] retains old value.

Source files
------------

// File: rtl/glb_psum_acc.sv
// Global partial-sum buffer: scalar and X_dim-wide vector reads, overwrite or
// accumulate writes, and a one-word-per-cycle clear. Optional macro: GLB_PSUM_SAT_EN.
module glb_psum_acc #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int X_dim         = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic                             read_req,
  input  logic [ADDR_BITWIDTH-1:0]         r_addr,
  output logic [DATA_BITWIDTH-1:0]         r_data,
  output logic                             r_valid,
  input  logic                             read_req_inter,
  input  logic [ADDR_BITWIDTH-1:0]         r_addr_inter,
  output logic [DATA_BITWIDTH*X_dim-1:0]   r_data_inter,
  output logic                             read_en_inter,
  input  logic                             write_en,
  input  logic                             acc_en,
  input  logic [ADDR_BITWIDTH-1:0]         w_addr,
  input  logic [DATA_BITWIDTH-1:0]         w_data,
  output logic                             sat_flag,
  output logic                             dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITWIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  // Handshake: requests are single-cycle pulses accepted only while not busy;
  // r_valid / read_en_inter pulse for exactly one cycle, one cycle after an accepted request.
  state_t                           r_state;
  logic [ADDR_BITWIDTH-1:0]         r_ptr;
  logic                             r_busy;
  logic [DATA_BITWIDTH-1:0]         r_rdata;
  logic                             r_rvalid;
  logic [DATA_BITWIDTH*X_dim-1:0]   r_vdata;
  logic                             r_vvalid;
  logic [DATA_BITWIDTH-1:0]         r_mem [DEPTH];

  logic                             w_idle;
  logic [DATA_BITWIDTH-1:0]         w_old;
  logic [DATA_BITWIDTH-1:0]         w_sum;
  logic                             w_ovf;
  logic [DATA_BITWIDTH-1:0]         w_acc_val;
  logic [DATA_BITWIDTH-1:0]         w_wr_val;
  logic                             w_sat_hit;
  logic [DATA_BITWIDTH*X_dim-1:0]   w_vec;

  localparam logic [DATA_BITWIDTH-1:0] MAX_POS = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
  localparam logic [DATA_BITWIDTH-1:0] MIN_NEG = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};

  assign w_idle = (r_state == S_IDLE);
  assign w_old  = r_mem[w_addr];
  assign w_sum  = w_old + w_data;
  // Signed overflow: operands share a sign that the sum does not.
  assign w_ovf  = (w_old[DATA_BITWIDTH-1] == w_data[DATA_BITWIDTH-1]) &&
                  (w_sum[DATA_BITWIDTH-1] != w_old[DATA_BITWIDTH-1]);

`ifdef GLB_PSUM_SAT_EN
  assign w_acc_val = w_ovf ? (w_old[DATA_BITWIDTH-1] ? MIN_NEG : MAX_POS) : w_sum;
  assign w_sat_hit = w_idle && write_en && acc_en && w_ovf;
`else
  assign w_acc_val = w_sum;
  assign w_sat_hit = 1'b0;
`endif

  assign w_wr_val = acc_en ? w_acc_val : w_data;

  always_comb begin
    w_vec = '0;
    for (int k = 0; k < X_dim; k++) begin
      w_vec[k*DATA_BITWIDTH +: DATA_BITWIDTH] = r_mem[r_addr_inter + ADDR_BITWIDTH'(k)];
    end
  end

  // Memory is never reset; a reset edge only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else if (write_en) begin
        r_mem[w_addr] <= w_wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_busy   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_vdata  <= '0;
      r_vvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid <= read_req;
          if (read_req) begin
            r_rdata <= r_mem[r_addr];
          end
          r_vvalid <= read_req_inter;
          r_vdata  <= read_req_inter ? w_vec : '0;
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_rvalid <= 1'b0;
          r_vvalid <= 1'b0;
          r_vdata  <= '0;
          r_ptr    <= r_ptr + 1'b1;
          if (&r_ptr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GLB_PSUM_SAT_EN
  logic r_sat;
  // Entering CLEAR wins over a saturation in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_idle && clear_req) begin
      r_sat <= 1'b0;
    end else if (w_sat_hit) begin
      r_sat <= 1'b1;
    end
  end
  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

  assign busy          = r_busy;
  assign r_data        = r_rdata;
  assign r_valid       = r_rvalid;
  assign r_data_inter  = r_vdata;
  assign read_en_inter = r_vvalid;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_glb_psum_acc.sv
// Scoreboard bench for glb_psum_acc: directed vectors push expected read data,
// a negedge monitor pops and compares on r_valid / read_en_inter.
module tb_glb_psum_acc;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int XD = 3;
  localparam int VW = DW * XD;

`ifdef GLB_PSUM_SAT_EN
  localparam logic [DW-1:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [DW-1:0] EXP_NEG_OVF = 16'h8000;
  localparam logic          EXP_SAT     = 1'b1;
`else
  localparam logic [DW-1:0] EXP_POS_OVF = 16'h8000;
  localparam logic [DW-1:0] EXP_NEG_OVF = 16'h7FFF;
  localparam logic          EXP_SAT     = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          clear_req;
  logic          busy;
  logic          read_req;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          read_req_inter;
  logic [AW-1:0] r_addr_inter;
  logic [VW-1:0] r_data_inter;
  logic          read_en_inter;
  logic          write_en;
  logic          acc_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          sat_flag;
  logic          dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [VW-1:0] exp_vq[$];

  glb_psum_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .read_req(read_req), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .read_req_inter(read_req_inter), .r_addr_inter(r_addr_inter),
    .r_data_inter(r_data_inter), .read_en_inter(read_en_inter),
    .write_en(write_en), .acc_en(acc_en), .w_addr(w_addr), .w_data(w_data),
    .sat_flag(sat_flag), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic acc);
    write_en = 1'b1; acc_en = acc; w_addr = a; w_data = d;
    tick();
    write_en = 1'b0; acc_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    read_req = 1'b1; r_addr = a;
    exp_q.push_back(e);
    tick();
    read_req = 1'b0;
  endtask

  task automatic vrd(input logic [AW-1:0] a, input logic [VW-1:0] e);
    read_req_inter = 1'b1; r_addr_inter = a;
    exp_vq.push_back(e);
    tick();
    read_req_inter = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (r_valid) begin
      if (exp_q.size() == 0) chk("scalar_unexpected_valid", {63'b0, r_valid}, 64'd0);
      else chk("scalar_data", {48'b0, r_data}, {48'b0, exp_q.pop_front()});
    end
    if (read_en_inter) begin
      if (exp_vq.size() == 0) chk("vector_unexpected_valid", {63'b0, read_en_inter}, 64'd0);
      else chk("vector_data", {16'b0, r_data_inter}, {16'b0, exp_vq.pop_front()});
    end
  end

  initial begin
    int busy_cnt;
    reset = 1'b1; clear_req = 1'b0; read_req = 1'b0; r_addr = '0;
    read_req_inter = 1'b0; r_addr_inter = '0; write_en = 1'b0; acc_en = 1'b0;
    w_addr = '0; w_data = '0;
    repeat (3) tick();
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_r_valid", {63'b0, r_valid}, 64'd0);
    chk("reset_r_data", {48'b0, r_data}, 64'd0);
    chk("reset_read_en_inter", {63'b0, read_en_inter}, 64'd0);
    chk("reset_r_data_inter", {16'b0, r_data_inter}, 64'd0);
    chk("reset_sat_flag", {63'b0, sat_flag}, 64'd0);
    chk("reset_state", {63'b0, dbg_state}, 64'd0);
    reset = 1'b0;
    tick();

    // overwrite then scalar read; r_valid drops and r_data holds
    wr(10'd5, 16'd100, 1'b0);
    rd(10'd5, 16'd100);
    tick();
    chk("r_valid_drop", {63'b0, r_valid}, 64'd0);
    chk("r_data_hold", {48'b0, r_data}, 64'd100);

    // back-to-back accumulate
    wr(10'd7, 16'd10, 1'b0);
    wr(10'd7, 16'd5, 1'b1);
    wr(10'd7, 16'd5, 1'b1);
    wr(10'd7, 16'd5, 1'b1);
    rd(10'd7, 16'd25);

    // read-first with concurrent scalar, vector and write
    wr(10'd8, 16'd1, 1'b0);
    wr(10'd9, 16'd11, 1'b0);
    wr(10'd10, 16'd3, 1'b0);
    write_en = 1'b1; acc_en = 1'b0; w_addr = 10'd9; w_data = 16'd50;
    read_req = 1'b1; r_addr = 10'd9;
    read_req_inter = 1'b1; r_addr_inter = 10'd8;
    exp_q.push_back(16'd11);
    exp_vq.push_back({16'd3, 16'd11, 16'd1});
    tick();
    write_en = 1'b0; read_req = 1'b0; read_req_inter = 1'b0;
    rd(10'd9, 16'd50);

    // vector wrap past the top address
    wr(10'd1023, 16'd1, 1'b0);
    wr(10'd0, 16'd2, 1'b0);
    wr(10'd1, 16'd3, 1'b0);
    vrd(10'd1023, {16'd3, 16'd2, 16'd1});
    tick();
    chk("vec_en_drop", {63'b0, read_en_inter}, 64'd0);
    chk("vec_data_zero", {16'b0, r_data_inter}, 64'd0);

    // signed accumulate without overflow
    wr(10'd20, 16'hFFF6, 1'b0);
    wr(10'd20, 16'd3, 1'b1);
    rd(10'd20, 16'hFFF9);
    chk("sat_flag_no_ovf", {63'b0, sat_flag}, 64'd0);

    // positive and negative overflow
    wr(10'd0, 16'd32767, 1'b0);
    wr(10'd0, 16'd1, 1'b1);
    chk("sat_flag_pos_ovf", {63'b0, sat_flag}, {63'b0, EXP_SAT});
    rd(10'd0, EXP_POS_OVF);
    wr(10'd2, 16'h8000, 1'b0);
    wr(10'd2, 16'hFFFF, 1'b1);
    rd(10'd2, EXP_NEG_OVF);
    chk("sat_flag_sticky", {63'b0, sat_flag}, {63'b0, EXP_SAT});

    // full clear with requests hammered while busy
    for (int i = 0; i < 1024; i++) wr(i[AW-1:0], DW'(i + 1), 1'b0);
    clear_req = 1'b1; read_req = 1'b1; r_addr = 10'd3;
    exp_q.push_back(16'd4);
    tick();
    clear_req = 1'b0; read_req = 1'b0;
    chk("clear_sat_cleared", {63'b0, sat_flag}, 64'd0);
    busy_cnt = 0;
    while (busy && busy_cnt < 2000) begin
      busy_cnt++;
      write_en = 1'b1; acc_en = 1'b0; w_addr = 10'd50; w_data = 16'hBEEF;
      read_req = 1'b1; r_addr = 10'd7;
      read_req_inter = 1'b1; r_addr_inter = 10'd7;
      clear_req = 1'b1;
      tick();
    end
    write_en = 1'b0; read_req = 1'b0; read_req_inter = 1'b0; clear_req = 1'b0;
    chk("busy_cycles", 64'(busy_cnt), 64'd1024);
    rd(10'd0, 16'd0);
    rd(10'd3, 16'd0);
    rd(10'd50, 16'd0);
    rd(10'd1023, 16'd0);
    vrd(10'd1022, 48'd0);

    // reset in the middle of a clear
    for (int i = 0; i < 128; i++) wr(i[AW-1:0], DW'(16'h100 + i), 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (100) tick();
    reset = 1'b1; write_en = 1'b1; acc_en = 1'b0; w_addr = 10'd101; w_data = 16'hDEAD;
    tick();
    chk("midclear_busy", {63'b0, busy}, 64'd0);
    chk("midclear_state", {63'b0, dbg_state}, 64'd0);
    reset = 1'b0; write_en = 1'b0;
    rd(10'd0, 16'd0);
    rd(10'd99, 16'd0);
    rd(10'd100, 16'h164);
    rd(10'd101, 16'h165);

    repeat (3) tick();
    chk("scalar_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("vector_queue_drained", 64'(exp_vq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
